// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : RV32I memory-access stage. Issues loads/stores on a req/ack
//            data port, stalls execute while an access is outstanding,
//            aborts accesses that never complete, and drives write-back
//            and register-read forwarding.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_rd_number,
    input  logic [31:0] i_result,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_val,
    input  logic [31:0] i_rs2_val,
    input  logic [31:0] i_immediate,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_func3,
    output logic        o_pipeline_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [4:0]  o_mem_rd_number,
    output logic [31:0] o_mem_result,
    output logic        o_mem_valid,
    output logic [4:0]  o_rd_number,
    output logic [31:0] o_result,
    output logic        o_wb_en,
    output logic        o_misaligned,
    output logic        o_mem_fault
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_ALU   = 7'b0110011;
    localparam logic [6:0] c_OP_ALUI  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    // Counter only has to reach TIMEOUT_CYCLES-1
    localparam int               CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Registered state
    state_t             r_state_q,       w_state_d;
    logic               r_mem_req_q,     w_mem_req_d;
    logic               r_mem_we_q,      w_mem_we_d;
    logic [31:0]        r_mem_addr_q,    w_mem_addr_d;
    logic [31:0]        r_mem_wdata_q,   w_mem_wdata_d;
    logic [3:0]         r_mem_wstrb_q,   w_mem_wstrb_d;
    logic [4:0]         r_rd_number_q,   w_rd_number_d;
    logic [31:0]        r_result_q,      w_result_d;
    logic               r_wb_en_q,       w_wb_en_d;
    logic               r_misaligned_q,  w_misaligned_d;
    logic               r_mem_fault_q,   w_mem_fault_d;
    logic [CNT_W-1:0]   r_cnt_q,         w_cnt_d;
    logic [1:0]         r_lane_q,        w_lane_d;
    logic [2:0]         r_ld_func3_q,    w_ld_func3_d;
    logic [4:0]         r_ld_rd_q,       w_ld_rd_d;

    // Decode wires
    logic [31:0]        w_addr;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_is_mem;
    logic               w_f3_legal;
    logic               w_misalign;
    logic               w_mem_go;
    logic               w_mem_bad;
    logic               w_writes_op;
    logic               w_writes;
    logic [31:0]        w_st_wdata;
    logic [3:0]         w_st_wstrb;
    logic [31:0]        w_ld_shift;
    logic [31:0]        w_ld_data;
    logic               w_ack_now;
    logic               w_timeout;

    // Inputs with no consumer in this stage
    logic               w_unused;
    assign w_unused = &{1'b0, i_pc, i_immediate[31:12]};

    // Decode the incoming instruction: address, legality, alignment, store lanes
    always_comb begin
        w_addr     = i_rs1_val + {{20{i_immediate[11]}}, i_immediate[11:0]};
        w_is_load  = (i_opcode == c_OP_LOAD);
        w_is_store = (i_opcode == c_OP_STORE);
        w_is_mem   = w_is_load | w_is_store;

        case (i_func3)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = w_is_load;
            default:                w_f3_legal = 1'b0;
        endcase

        w_misalign = ((i_func3[1:0] == 2'b01) && w_addr[0]) ||
                     ((i_func3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
        w_mem_go   = w_is_mem && w_f3_legal && !w_misalign;
        w_mem_bad  = w_is_mem && (!w_f3_legal || w_misalign);

        case (i_opcode)
            c_OP_ALU, c_OP_ALUI, c_OP_JAL, c_OP_JALR,
            c_OP_LUI, c_OP_AUIPC, c_OP_LOAD: w_writes_op = 1'b1;
            default:                         w_writes_op = 1'b0;
        endcase
        w_writes = w_writes_op && (i_rd_number != 5'd0);

        w_st_wdata = i_rs2_val;
        w_st_wstrb = 4'b1111;
        case (i_func3[1:0])
            2'b00: begin
                w_st_wdata = {4{i_rs2_val[7:0]}};
                w_st_wstrb = 4'b0001 << w_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{i_rs2_val[15:0]}};
                w_st_wstrb = 4'b0011 << w_addr[1:0];
            end
            default: ;
        endcase
    end

    // Extract and extend the loaded byte/halfword from the returned word
    always_comb begin
        w_ld_shift = i_mem_rdata >> {r_lane_q, 3'b000};
        case (r_ld_func3_q)
            3'b000:  w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'b100:  w_ld_data = {24'd0, w_ld_shift[7:0]};
            3'b101:  w_ld_data = {16'd0, w_ld_shift[15:0]};
            default: w_ld_data = i_mem_rdata;
        endcase
        w_ack_now = (r_state_q == S_BUSY) && i_mem_ack;
        w_timeout = (r_state_q == S_BUSY) && !i_mem_ack && (r_cnt_q == c_CNT_LAST);
    end

    // Next-state logic for the access FSM, request fields and write-back
    always_comb begin
        w_state_d      = r_state_q;
        w_mem_req_d    = r_mem_req_q;
        w_mem_we_d     = r_mem_we_q;
        w_mem_addr_d   = r_mem_addr_q;
        w_mem_wdata_d  = r_mem_wdata_q;
        w_mem_wstrb_d  = r_mem_wstrb_q;
        w_rd_number_d  = r_rd_number_q;
        w_result_d     = r_result_q;
        w_wb_en_d      = 1'b0;
        w_misaligned_d = 1'b0;
        w_mem_fault_d  = 1'b0;
        w_cnt_d        = r_cnt_q;
        w_lane_d       = r_lane_q;
        w_ld_func3_d   = r_ld_func3_q;
        w_ld_rd_d      = r_ld_rd_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_mem_go) begin
                    w_state_d     = S_BUSY;
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = w_is_store;
                    w_mem_addr_d  = {w_addr[31:2], 2'b00};
                    w_mem_wdata_d = w_is_store ? w_st_wdata : 32'd0;
                    w_mem_wstrb_d = w_is_store ? w_st_wstrb : 4'b0000;
                    w_lane_d      = w_addr[1:0];
                    w_ld_func3_d  = i_func3;
                    w_ld_rd_d     = i_rd_number;
                    w_cnt_d       = '0;
                end else if (w_mem_bad) begin
                    w_misaligned_d = 1'b1;
                end else begin
                    w_rd_number_d = i_rd_number;
                    w_result_d    = i_result;
                    w_wb_en_d     = w_writes;
                end
            end
            S_BUSY: begin
                if (i_mem_ack) begin
                    w_state_d   = S_IDLE;
                    w_mem_req_d = 1'b0;
                    if (!r_mem_we_q) begin
                        w_rd_number_d = r_ld_rd_q;
                        w_result_d    = w_ld_data;
                        w_wb_en_d     = (r_ld_rd_q != 5'd0);
                    end
                end else if (w_timeout) begin
                    w_state_d     = S_IDLE;
                    w_mem_req_d   = 1'b0;
                    w_mem_fault_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // Stall and same-cycle forwarding toward execute and register-read
    always_comb begin
        o_pipeline_stall = 1'b0;
        o_mem_valid      = 1'b0;
        o_mem_result     = i_result;
        o_mem_rd_number  = i_rd_number;
        if (!reset) begin
            if (r_state_q == S_IDLE) begin
                o_pipeline_stall = w_mem_go;
                o_mem_valid      = w_writes && !w_is_load;
            end else begin
                o_pipeline_stall = !i_mem_ack && !w_timeout;
                if (w_ack_now && !r_mem_we_q) begin
                    o_mem_valid  = 1'b1;
                    o_mem_result = w_ld_data;
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_mem_req_q    <= 1'b0;
            r_mem_we_q     <= 1'b0;
            r_mem_addr_q   <= 32'd0;
            r_mem_wdata_q  <= 32'd0;
            r_mem_wstrb_q  <= 4'd0;
            r_rd_number_q  <= 5'd0;
            r_result_q     <= 32'd0;
            r_wb_en_q      <= 1'b0;
            r_misaligned_q <= 1'b0;
            r_mem_fault_q  <= 1'b0;
            r_cnt_q        <= '0;
            r_lane_q       <= 2'd0;
            r_ld_func3_q   <= 3'd0;
            r_ld_rd_q      <= 5'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_mem_req_q    <= w_mem_req_d;
            r_mem_we_q     <= w_mem_we_d;
            r_mem_addr_q   <= w_mem_addr_d;
            r_mem_wdata_q  <= w_mem_wdata_d;
            r_mem_wstrb_q  <= w_mem_wstrb_d;
            r_rd_number_q  <= w_rd_number_d;
            r_result_q     <= w_result_d;
            r_wb_en_q      <= w_wb_en_d;
            r_misaligned_q <= w_misaligned_d;
            r_mem_fault_q  <= w_mem_fault_d;
            r_cnt_q        <= w_cnt_d;
            r_lane_q       <= w_lane_d;
            r_ld_func3_q   <= w_ld_func3_d;
            r_ld_rd_q      <= w_ld_rd_d;
        end
    end

    assign o_mem_req    = r_mem_req_q;
    assign o_mem_we     = r_mem_we_q;
    assign o_mem_addr   = r_mem_addr_q;
    assign o_mem_wdata  = r_mem_wdata_q;
    assign o_mem_wstrb  = r_mem_wstrb_q;
    assign o_rd_number  = r_rd_number_q;
    assign o_result     = r_result_q;
    assign o_wb_en      = r_wb_en_q;
    assign o_misaligned = r_misaligned_q;
    assign o_mem_fault  = r_mem_fault_q;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage sitting directly downstream of the execute stage.
- Consumes the execute stage's registered outputs: rd, result, pc, rs1/rs2 values, immediate, opcode, func3.
- Performs RV32I loads and stores over a req/ack data-memory port and stalls execute while an access is outstanding.
- Drives the register-file write-back port and forwarding signals to register-read.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in BUSY without i_mem_ack before the access is aborted; must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_rd_number  in  5  destination register from execute.
- i_result  in  32  execute result: ALU, link, LUI or AUIPC value.
- i_pc  in  32  instruction pc; pass-through only.
- i_rs1_val  in  32  base address operand.
- i_rs2_val  in  32  store data.
- i_immediate  in  32  offset; bits [11:0] are used, sign-extended.
- i_opcode  in  7  RV32I opcode.
- i_func3  in  3  access size/sign.
- o_pipeline_stall  out  1  to execute; execute holds its registers while high.
- o_mem_req  out  1  memory request, held until acknowledged.
- o_mem_we  out  1  1 = store.
- o_mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- o_mem_wdata  out  32  store data, lane-replicated.
- o_mem_wstrb  out  4  byte enables.
- i_mem_ack  in  1  request accepted/completed this cycle.
- i_mem_rdata  in  32  read word, valid when i_mem_ack is high.
- o_mem_rd_number  out  5  combinational forward: destination register.
- o_mem_result  out  32  combinational forward: value.
- o_mem_valid  out  1  combinational forward: valid.
- o_rd_number  out  5  registered write-back destination.
- o_result  out  32  registered write-back data.
- o_wb_en  out  1  registered write-back enable.
- o_misaligned  out  1  one-cycle pulse: misaligned access or illegal func3.
- o_mem_fault  out  1  one-cycle pulse: access timed out.

Behaviour:
- Address: addr = i_rs1_val + sext(i_immediate[11:0]), 32-bit with wrap-around.
- Memory op: i_opcode is LOAD (0000011) or STORE (0100011).
- Writing op: opcode is ALU, ALUI, JAL, JALR, LUI, AUIPC or LOAD, and rd != 0.
- Legal func3, loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- Legal func3, stores: SB 000, SH 001, SW 010.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Misaligned or illegal-func3 op: no request; o_misaligned pulses the next cycle; no write-back; no stall.
- State IDLE, legal memory op present:
  - Register o_mem_addr, o_mem_we, o_mem_wdata and o_mem_wstrb; set o_mem_req=1; go to BUSY.
  - o_pipeline_stall=1 this cycle.
- State IDLE, non-memory op:
  - On the next edge o_rd_number<=i_rd_number, o_result<=i_result, o_wb_en<=writing op.
  - No stall.
- State BUSY:
  - o_mem_req and all request fields held constant.
  - o_pipeline_stall = !i_mem_ack.
  - On i_mem_ack: o_mem_req<=0; go to IDLE.
  - On a load ack: o_result<=formatted data, o_wb_en<=(rd!=0). On a store ack: o_wb_en<=0.
  - Because stall drops in the ack cycle, execute advances and the next cycle presents a new instruction; there is no re-issue.
- Timeout: a counter clears on entry to BUSY and increments each BUSY cycle without ack. When it equals TIMEOUT_CYCLES−1 without ack:
  - Drop the request and go to IDLE.
  - o_mem_fault pulses next cycle; o_wb_en<=0; o_pipeline_stall is 0 that cycle.
- An ack arriving in the same cycle as the timeout has priority over the timeout.
- Minimum memory-op latency is 2 cycles: the detect cycle plus the ack cycle.
- o_wb_en<=0 on every stalled cycle (bubble).
- Load formatting uses lane = addr[1:0]:
  - LB/LBU: byte at lane, sign- or zero-extended.
  - LH/LHU: halfword at lane[1], sign- or zero-extended.
  - LW: whole word.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001<<lane.
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011<<lane.
  - SW: wdata = rs2, wstrb = 1111.
- Forwarding, combinational:
  - IDLE with a writing non-load op: o_mem_valid=1, o_mem_result=i_result.
  - BUSY with a load ack: o_mem_valid=1, o_mem_result=formatted data.
  - Otherwise o_mem_valid=0.
  - o_mem_rd_number=i_rd_number always.
- Reset: all registered outputs go to 0, including o_mem_req, o_wb_en, o_misaligned and o_mem_fault; state goes to IDLE; the counter clears.
- Reset during BUSY abandons the access: req drops the next cycle, with no fault and no write-back.
- o_pipeline_stall is 0 during reset.

Test Plan:
- ALU op, rd=5, i_result=0x1234 -> next cycle o_wb_en=1, o_rd_number=5, o_result=0x1234; no stall, no req.
- LW, rs1=0x100, imm=0x004, ack returned 3 cycles after req with rdata=0xDEADBEEF:
  - o_mem_addr=0x104; stall high 4 cycles.
  - o_result=0xDEADBEEF, wb_en=1 the cycle after ack.
- LB and LBU, addr=0x103, rdata=0x80FFFFFF -> results 0xFFFFFF80 and 0x00000080.
- SB, rs2=0xAB, addr=0x102 -> wdata=0xABABABAB, wstrb=0100, we=1; no write-back after ack.
- LW, addr=0x102 -> no req; o_misaligned pulses once; no stall; wb_en=0.
- Timeouts:
  - TIMEOUT_CYCLES=4, LW, ack never asserted -> req held 4 cycles then drops; o_mem_fault pulses; stall releases; wb_en=0.
  - Reset asserted in BUSY -> req=0 next cycle, no fault.
